// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, op/state enums, mstatus bit indices and irq-to-mip mapping.
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  typedef enum logic [1:0] {OP_NONE, OP_RW, OP_RS, OP_RC} csr_op_e;
  typedef enum logic {IDLE, FLUSH} state_e;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  function automatic logic [4:0] irq_bit(input int k);
    return k == 0 ? 5'd3 : k == 1 ? 5'd7 : k == 2 ? 5'd11 : 5'(13 + k);
  endfunction
  function automatic logic [31:0] irq_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < n; k++) m[irq_bit(k)] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/csr_irq_prio.sv
// csr_irq_prio: picks the winning enabled interrupt; MEI > MSI > MTI > local lines by index.
module csr_irq_prio
  import csr_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [31:0] pend_i,
  output logic        valid_o,
  output logic [4:0]  code_o
);
  always_comb begin
    code_o = '0;
    for (int k = NUM_IRQ - 1; k >= 3; k--) if (pend_i[irq_bit(k)]) code_o = irq_bit(k);
    code_o = pend_i[7]  ? 5'd7  : code_o;
    code_o = pend_i[3]  ? 5'd3  : code_o;
    code_o = pend_i[11] ? 5'd11 : code_o;
  end
  assign valid_o = |pend_i;
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file, interrupt trap/mret sequencing and post-redirect flush.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_IRQ      = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               pc_valid_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [1:0]         csr_op_i,
  input  logic [XLEN-1:0]    csr_wdata_i,
  output logic [XLEN-1:0]    csr_rdata_o,
  output logic               illegal_csr_o,
  input  logic               is_mret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               instr_retired_i,
  output logic               redirect_o,
  output logic [XLEN-1:0]    redirect_pc_o
);
  localparam logic [31:0] IRQ_MASK = irq_mask(NUM_IRQ);
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        st_mie_q, st_mpie_q;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mip_q, mip_d;
  logic [63:0] mcycle_q, minstret_q;
  logic [31:0] old, wval, trap_pc;
  logic        legal, we, pend_v, take_mret, take_trap;
  logic [4:0]  code;
  csr_op_e     op;
  assign op = csr_op_e'(csr_op_i);
  always_comb begin
    mip_d = '0;
    for (int k = 0; k < NUM_IRQ; k++) mip_d[irq_bit(k)] = irq_i[k];
  end
  always_comb begin
    legal = 1'b1;
    old   = '0;
    case (csr_addr_i)
      CSR_MSTATUS:   old = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
      CSR_MIE:       old = mie_q;
      CSR_MTVEC:     old = mtvec_q;
      CSR_MSCRATCH:  old = mscratch_q;
      CSR_MEPC:      old = mepc_q;
      CSR_MCAUSE:    old = mcause_q;
      CSR_MIP:       old = mip_q;
      CSR_MCYCLE:    old = mcycle_q[31:0];
      CSR_MCYCLEH:   old = mcycle_q[63:32];
      CSR_MINSTRET:  old = minstret_q[31:0];
      CSR_MINSTRETH: old = minstret_q[63:32];
      default:       legal = 1'b0;
    endcase
  end
  assign wval          = op == OP_RW ? csr_wdata_i : op == OP_RS ? old | csr_wdata_i : old & ~csr_wdata_i;
  assign csr_rdata_o   = (op != OP_NONE && legal) ? old : '0;
  assign illegal_csr_o = op != OP_NONE && !legal;
  // set/clear with a zero operand is a pure read, so counters keep running under csrr
  assign we = op != OP_NONE && legal && !take_trap && !(op != OP_RW && csr_wdata_i == '0);
  csr_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .pend_i (mip_q & mie_q),
    .valid_o(pend_v),
    .code_o (code)
  );
  always_comb begin
    take_mret     = state_q == IDLE && is_mret_i;
    take_trap     = state_q == IDLE && !is_mret_i && pend_v && st_mie_q && pc_valid_i;
    state_d       = state_q;
    cnt_d         = cnt_q;
    trap_pc       = {mtvec_q[31:2], 2'b00} + (mtvec_q[0] ? {25'b0, code, 2'b00} : 32'd0);
    redirect_o    = take_mret || take_trap;
    redirect_pc_o = take_mret ? mepc_q : take_trap ? trap_pc : '0;
    if (redirect_o) begin
      state_d = FLUSH;
      cnt_d   = 3'(FLUSH_CYCLES - 1);
    end else if (state_q == FLUSH) begin
      state_d = cnt_q == 3'd0 ? IDLE : FLUSH;
      cnt_d   = cnt_q == 3'd0 ? cnt_q : cnt_q - 3'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mip_q      <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mip_q    <= mip_d;
      mcycle_q <= mcycle_q + 64'd1;
      if (instr_retired_i && !take_trap) minstret_q <= minstret_q + 64'd1;
      if (we) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            st_mie_q  <= wval[MIE_BIT];
            st_mpie_q <= wval[MPIE_BIT];
          end
          CSR_MIE:       mie_q      <= wval & IRQ_MASK;
          CSR_MTVEC:     mtvec_q    <= {wval[31:2], wval[1] ? mtvec_q[1:0] : wval[1:0]};
          CSR_MSCRATCH:  mscratch_q <= wval;
          CSR_MEPC:      mepc_q     <= {wval[31:2], 2'b00};
          CSR_MCAUSE:    mcause_q   <= wval;
          CSR_MCYCLE:    mcycle_q   <= {mcycle_q[63:32], wval};
          CSR_MCYCLEH:   mcycle_q   <= {wval, mcycle_q[31:0]};
          CSR_MINSTRET:  minstret_q <= {minstret_q[63:32], wval};
          CSR_MINSTRETH: minstret_q <= {wval, minstret_q[31:0]};
          default: ;
        endcase
      end
      if (take_trap) begin
        mepc_q    <= pc_i & ~32'h3;
        mcause_q  <= {1'b1, 26'b0, code};
        st_mpie_q <= st_mie_q;
        st_mie_q  <= 1'b0;
      end
      if (take_mret) begin
        st_mie_q  <= st_mpie_q;
        st_mpie_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed literal checks plus randomized traffic against a behavioural CSR/trap model.
module tb_csr_trap_unit;
  localparam int NIRQ = 8;
  localparam int FC   = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] pc_i = '0, csr_wdata_i = '0, csr_rdata_o, redirect_pc_o;
  logic [11:0] csr_addr_i = '0;
  logic [1:0]  csr_op_i = '0;
  logic        pc_valid_i = 1'b0, is_mret_i = 1'b0, instr_retired_i = 1'b0;
  logic        illegal_csr_o, redirect_o;
  logic [NIRQ-1:0] irq_i = '0;
  int vectors = 0, miscompares = 0;
  logic        m_valid = 1'b0, m_mieb, m_mpieb;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
  logic [63:0] m_cyc, m_ret, cyc_n, ret_n;
  int          m_block;
  logic        n_red, n_trap, p_red, p_trap;
  logic [31:0] n_pc, p_pc, p_old, p_w, p_mip;
  logic [4:0]  n_code, p_code;
  logic [11:0] addrs [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                              12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'h301};

  csr_trap_unit #(.XLEN(32), .NUM_IRQ(NIRQ), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .csr_addr_i(csr_addr_i),
    .csr_op_i(csr_op_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .illegal_csr_o(illegal_csr_o), .is_mret_i(is_mret_i), .irq_i(irq_i),
    .instr_retired_i(instr_retired_i), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );
  always #5 clk = ~clk;

  function automatic int mip_pos(input int k);
    return k < 3 ? 4 * k + 3 : 13 + k;
  endfunction
  function automatic logic [31:0] impl_mask();
    logic [31:0] m = 0;
    for (int k = 0; k < NIRQ; k++) m = m | (32'h1 << mip_pos(k));
    return m;
  endfunction
  function automatic logic legal_addr(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                     12'hB00, 12'hB02, 12'hB80, 12'hB82};
  endfunction
  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (m_mpieb ? 32'h80 : 32'h0) | (m_mieb ? 32'h8 : 32'h0);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ret[31:0];
      12'hB82: return m_ret[63:32];
      default: return 32'h0;
    endcase
  endfunction
  function automatic int top_code(input logic [31:0] p);
    if (p[11]) return 11;
    if (p[3]) return 3;
    if (p[7]) return 7;
    for (int b = 16; b < 32; b++) if (p[b]) return b;
    return 0;
  endfunction
  task automatic decide(output logic red, output logic [31:0] rpc, output logic trap, output logic [4:0] code);
    logic [31:0] p;
    logic idle;
    int c;
    p    = m_mip & m_mie;
    c    = top_code(p);
    idle = (m_block == 0);
    trap = idle && !is_mret_i && p != 0 && m_mieb && pc_valid_i;
    code = 5'(c);
    red  = (idle && is_mret_i) || trap;
    rpc  = (idle && is_mret_i) ? m_mepc :
           trap ? (m_mtvec & ~32'h3) + (m_mtvec[0] ? 32'(4 * c) : 32'd0) : 32'd0;
  endtask
  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  always @(negedge clk) if (m_valid) begin
    decide(n_red, n_pc, n_trap, n_code);
    check("redirect_o", 32'(redirect_o), 32'(n_red));
    check("redirect_pc_o", redirect_pc_o, n_pc);
    check("illegal_csr_o", 32'(illegal_csr_o), 32'(csr_op_i != 0 && !legal_addr(csr_addr_i)));
    check("csr_rdata_o", csr_rdata_o, (csr_op_i != 0 && legal_addr(csr_addr_i)) ? m_read(csr_addr_i) : 32'h0);
  end

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b1; m_mieb <= 1'b0; m_mpieb <= 1'b0; m_mie <= 0; m_mtvec <= 0; m_mscratch <= 0;
      m_mepc <= 0; m_mcause <= 0; m_mip <= 0; m_cyc <= 0; m_ret <= 0; m_block <= 0;
    end else begin
      decide(p_red, p_pc, p_trap, p_code);
      p_mip = 0;
      for (int k = 0; k < NIRQ; k++) if (irq_i[k]) p_mip = p_mip | (32'h1 << mip_pos(k));
      m_mip   <= p_mip;
      m_block <= p_red ? FC : (m_block > 0 ? m_block - 1 : 0);
      cyc_n = m_cyc + 1;
      ret_n = m_ret + ((instr_retired_i && !p_trap) ? 64'd1 : 64'd0);
      if (csr_op_i != 0 && legal_addr(csr_addr_i) && !p_trap && !(csr_op_i != 1 && csr_wdata_i == 0)) begin
        p_old = m_read(csr_addr_i);
        p_w = csr_op_i == 1 ? csr_wdata_i : csr_op_i == 2 ? (p_old | csr_wdata_i) : (p_old & ~csr_wdata_i);
        case (csr_addr_i)
          12'h300: begin m_mieb <= p_w[3]; m_mpieb <= p_w[7]; end
          12'h304: m_mie <= p_w & impl_mask();
          12'h305: m_mtvec <= {p_w[31:2], (p_w[1:0] < 2'd2) ? p_w[1:0] : m_mtvec[1:0]};
          12'h340: m_mscratch <= p_w;
          12'h341: m_mepc <= p_w & ~32'h3;
          12'h342: m_mcause <= p_w;
          12'hB00: cyc_n = {m_cyc[63:32], p_w};
          12'hB80: cyc_n = {p_w, m_cyc[31:0]};
          12'hB02: ret_n = {m_ret[63:32], p_w};
          12'hB82: ret_n = {p_w, m_ret[31:0]};
          default: ;
        endcase
      end
      m_cyc <= cyc_n;
      m_ret <= ret_n;
      if (p_trap) begin
        m_mepc <= pc_i & ~32'h3; m_mcause <= 32'h80000000 | 32'(p_code); m_mpieb <= m_mieb; m_mieb <= 1'b0;
      end
      if (p_red && !p_trap) begin m_mieb <= m_mpieb; m_mpieb <= 1'b1; end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    set_csr(2, 12'h300, 0); #2;
    check("rst_mstatus", csr_rdata_o, 32'h1800);
    check("rst_redirect", 32'(redirect_o), 32'h0);
    step();
    set_csr(2, 12'h305, 0); #2; check("rst_mtvec", csr_rdata_o, 32'h0); step();
    set_csr(1, 12'h305, 32'h101); irq_i = 8'b010; step();
    set_csr(1, 12'h304, 32'h80); step();
    set_csr(1, 12'h300, 32'h8); step();
    set_csr(0, 0, 0); pc_i = 32'h40; pc_valid_i = 1; #2;
    check("mti_redirect", 32'(redirect_o), 32'h1);
    check("mti_pc", redirect_pc_o, 32'h11C);
    step();
    pc_valid_i = 0; irq_i = 0;
    set_csr(2, 12'h341, 0); #2; check("mti_mepc", csr_rdata_o, 32'h40); step();
    set_csr(2, 12'h342, 0); #2; check("mti_mcause", csr_rdata_o, 32'h80000007); step();
    set_csr(2, 12'h300, 0); #2; check("mti_mstatus", csr_rdata_o, 32'h1880); step();
    set_csr(1, 12'h305, 32'h200); irq_i = 8'b110; step();
    set_csr(1, 12'h304, 32'h880); step();
    set_csr(2, 12'h300, 32'h8); step();
    set_csr(0, 0, 0); pc_i = 32'h80; pc_valid_i = 1; #2; check("prio_pc", redirect_pc_o, 32'h200); step();
    pc_valid_i = 0; irq_i = 0;
    set_csr(2, 12'h342, 0); #2; check("prio_mcause", csr_rdata_o, 32'h8000000B); step();
    set_csr(0, 0, 0); step(); step();
    is_mret_i = 1; #2; check("mret_pc", redirect_pc_o, 32'h80); step();
    is_mret_i = 0;
    set_csr(2, 12'h300, 0); #2; check("mret_mstatus", csr_rdata_o, 32'h1888); step();
    set_csr(1, 12'h300, 0); step();
    set_csr(2, 12'h300, 32'h8); step();
    set_csr(3, 12'h300, 32'h8); #2; check("rs_mstatus", csr_rdata_o, 32'h1808); step();
    set_csr(2, 12'h300, 0); #2; check("rc_mstatus", csr_rdata_o, 32'h1800); step();
    set_csr(1, 12'h305, 32'h303); step();
    set_csr(2, 12'h305, 0); #2; check("mtvec_warl", csr_rdata_o, 32'h300); step();
    set_csr(1, 12'h7C0, 32'hFFFF); #2;
    check("illegal_flag", 32'(illegal_csr_o), 32'h1);
    check("illegal_rdata", csr_rdata_o, 32'h0);
    step();
    set_csr(1, 12'h305, 32'h400); irq_i = 8'b001; step();
    set_csr(1, 12'h304, 32'h8); step();
    set_csr(1, 12'h300, 32'h88); step();
    set_csr(0, 0, 0); pc_valid_i = 1; is_mret_i = 1; #2; check("mret_wins", redirect_pc_o, 32'h80); step();
    is_mret_i = 0;
    #2; check("flush_1", 32'(redirect_o), 32'h0); step();
    #2; check("flush_2", 32'(redirect_o), 32'h0); step();
    #2; check("flush_trap", redirect_pc_o, 32'h400); check("flush_trap_v", 32'(redirect_o), 32'h1); step();
    pc_valid_i = 0; reset = 1; step();
    reset = 0; irq_i = 0; is_mret_i = 1; #2; check("rst_in_flush", 32'(redirect_o), 32'h1); step();
    is_mret_i = 0;
    set_csr(1, 12'hB00, 32'hFFFFFFFF); step();
    set_csr(2, 12'hB80, 0); step();
    #2; check("mcycleh_carry", csr_rdata_o, 32'h1); step();
    set_csr(1, 12'hB02, 32'h1234); instr_retired_i = 1; step();
    instr_retired_i = 0;
    set_csr(2, 12'hB02, 0); #2; check("minstret_write_wins", csr_rdata_o, 32'h1234); step();
    for (int i = 0; i < 4000; i++) begin
      csr_addr_i = addrs[$urandom_range(0, 12)];
      csr_op_i = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'd0;
      csr_wdata_i = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if (csr_addr_i == 12'h300 && $urandom_range(0, 1) == 1) csr_wdata_i = 32'h8;
      is_mret_i = ($urandom_range(0, 19) == 0);
      if (is_mret_i) csr_op_i = 0;
      pc_valid_i = ($urandom_range(0, 3) != 0);
      pc_i = $urandom;
      instr_retired_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) irq_i = NIRQ'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 0; set_csr(0, 0, 0); is_mret_i = 0; pc_valid_i = 0; step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
